hex_page_selector: RTL and testbench
====================================

Name: hex_page_selector

Overview:
- Sits directly upstream of the 4-digit hex display driver; produces the 16-bit value that driver shows.
- Captures a 32-bit debug word, for example CPU memory output or instruction, into a shadow register.
- Presents one 16-bit half ("page") at a time.
- Page changes on a debounced pushbutton press or on an optional auto-cycle timer.
- Provides a page indicator for the display decimal point.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before the debounced button changes state (10 ms at 100 MHz).
- AUTO_CYCLES, 100_000_000: cycles between automatic page toggles when auto mode is on (1 s at 100 MHz).

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  32  debug word to capture.
- data_valid  input  1  capture strobe; data_in is sampled on cycles where this is high.
- freeze  input  1  when high, captures are blocked and the shadow register holds.
- btn_raw  input  1  raw asynchronous pushbutton, active-high.
- auto_en  input  1  enables automatic page cycling.
- hex_val  output  16  selected half of the shadow register, to the display driver.
- page_hi  output  1  1 = upper half [31:16] shown; 0 = lower half [15:0] shown.
- dp_mask  output  4  active-high decimal-point enables, one per digit; bit 3 = leftmost digit.
- btn_press  output  1  one-cycle pulse on each debounced rising edge of the button.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - hex_val = 16'h0000, page_hi = 0, dp_mask = 4'b0000, btn_press = 0.
  - shadow = 32'h0, debounced button = 0, both synchronizer flops = 0.
  - debounce counter = 0, auto timer = 0.
- Reset asserted mid-operation clears all of the above on that edge, regardless of any other input.
- Synchronizer: btn_raw passes through a 2-flop synchronizer before the debouncer. The flops are btn_s1 then btn_s2.
- Debouncer:
  - When btn_s2 equals the debounced value, the counter clears to 0.
  - Otherwise the counter increments each cycle.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced value takes btn_s2 and the counter clears.
  - Any glitch back to the debounced value restarts the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES)+1.
- btn_press:
  - Registered; high for exactly one cycle, on the cycle after the debounced value rises 0->1.
  - Falling edges produce no pulse.
- Capture:
  - If data_valid && !freeze at edge n, shadow = data_in after edge n.
  - If freeze is high, shadow holds even when data_valid is high.
- Page state (two states, LO and HI):
  - Toggle event = btn_press, or an auto timeout.
  - Auto timeout = auto_en high and auto timer at AUTO_CYCLES-1.
  - Every toggle event flips the page.
  - btn_press and an auto timeout in the same cycle produce a single toggle, not two.
- Auto timer:
  - Increments while auto_en is high.
  - Clears on timeout, on btn_press, and whenever auto_en is low.
  - Width is $clog2(AUTO_CYCLES)+1.
- Outputs:
  - hex_val = page_hi ? shadow[31:16] : shadow[15:0], registered.
  - dp_mask = page_hi ? 4'b1000 : 4'b0000, registered.
  - Both are updated on the edge after shadow or page changes.
- Latency:
  - data_valid sampled at edge n -> hex_val reflects it after edge n+1.
  - btn_press high during cycle m -> page_hi flips at edge m+1 -> hex_val and dp_mask follow at edge m+2.
- Boundary cases:
  - Capture and page toggle in the same cycle: both take effect, and hex_val after the next edge shows the new page of the new data.
  - Button held indefinitely: one btn_press only.
  - auto_en deasserted mid-count: the timer is lost and restarts from 0 on re-enable.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_CYCLES=8):
- Reset, then data_in=32'hDEAD_BEEF with data_valid for 1 cycle -> two edges later hex_val=16'hBEEF, page_hi=0, dp_mask=4'b0000.
- btn_raw high for 10 cycles, then low -> exactly one btn_press pulse, page_hi=1, hex_val=16'hDEAD, dp_mask=4'b1000. A 2-cycle btn_raw glitch -> no pulse and no page change.
- freeze=1, data_in=32'h1234_5678 with data_valid -> hex_val stays 16'hDEAD. freeze=0 with data_valid -> hex_val=16'h1234.
- auto_en=1, no button -> page_hi toggles every 8 cycles (0->1->0). auto_en dropped at timer=5, then re-raised -> next toggle 8 cycles after re-raise.
- Button press timed so btn_press coincides with an auto timeout -> page flips once only and the timer restarts from 0.
- Assert reset while page_hi=1 and a debounce count is in progress -> next cycle hex_val=0, page_hi=0, dp_mask=0, btn_press=0. A held btn_raw needs a full debounce interval before a new pulse.

Source files
------------

// File: rtl/hex_page_selector_if.sv
// Bus bundle between the debug-word source/button inputs and the page selector.
// The master side drives capture and control; the slave side returns the display value.
interface hex_page_selector_if;
    logic [31:0] data_in;
    logic        data_valid;
    logic        freeze;
    logic        btn_raw;
    logic        auto_en;
    logic [15:0] hex_val;
    logic        page_hi;
    logic [3:0]  dp_mask;
    logic        btn_press;

    modport master (
        output data_in, data_valid, freeze, btn_raw, auto_en,
        input  hex_val, page_hi, dp_mask, btn_press
    );

    modport slave (
        input  data_in, data_valid, freeze, btn_raw, auto_en,
        output hex_val, page_hi, dp_mask, btn_press
    );
endinterface

// File: rtl/hex_page_selector.sv
// Shadows a 32-bit debug word and presents one 16-bit page to the hex display driver.
// Pages flip on a debounced button press or on an optional auto-cycle timer.
module hex_page_selector #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int AUTO_CYCLES     = 100_000_000
) (
    input logic             clk,
    input logic             reset,
    hex_page_selector_if.slave bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int AUTO_W = $clog2(AUTO_CYCLES) + 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);

    typedef enum logic {LO, HI} page_t;

    logic              btn_s1;
    logic              btn_s2;
    logic              btn_db;
    logic              btn_db_d;
    logic [DB_W-1:0]   db_cnt;
    logic              press;
    logic [AUTO_W-1:0] auto_cnt;
    logic              timeout;
    logic              toggle;
    page_t             page;
    logic [31:0]       shadow;
    logic [15:0]       hex_reg;
    logic [3:0]        dp_reg;

    assign timeout = bus.auto_en && (auto_cnt == AUTO_LAST);
    // A press and a timeout landing together still give only one flip.
    assign toggle  = press || timeout;

    // Button path: synchronizer, debouncer, rising-edge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            btn_s1   <= bus.btn_raw;
            btn_s2   <= btn_s1;
            btn_db_d <= btn_db;
            press    <= btn_db && !btn_db_d;
            if (btn_s2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Page state and auto timer
    always_ff @(posedge clk) begin
        if (reset) begin
            page     <= LO;
            auto_cnt <= '0;
        end else begin
            if (!bus.auto_en || toggle) auto_cnt <= '0;
            else                        auto_cnt <= auto_cnt + 1'b1;
            if (toggle) page <= (page == LO) ? HI : LO;
        end
    end

    // Capture into shadow, then register the selected page for the display
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            hex_reg <= '0;
            dp_reg  <= '0;
        end else begin
            if (bus.data_valid && !bus.freeze) shadow <= bus.data_in;
            hex_reg <= (page == HI) ? shadow[31:16] : shadow[15:0];
            dp_reg  <= (page == HI) ? 4'b1000 : 4'b0000;
        end
    end

    assign bus.hex_val   = hex_reg;
    assign bus.page_hi   = (page == HI);
    assign bus.dp_mask   = dp_reg;
    assign bus.btn_press = press;
endmodule

// File: tb/tb_hex_page_selector.sv
// Directed bench for hex_page_selector with short debounce and auto intervals.
module tb_hex_page_selector;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   pulses;

    hex_page_selector_if bus ();

    hex_page_selector #(.DEBOUNCE_CYCLES(4), .AUTO_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold the button 10 cycles, release, let it settle; returns pulses seen.
    task automatic press_count(output int n);
        n = 0;
        bus.btn_raw = 1'b1;
        repeat (10) begin tick(); if (bus.btn_press) n++; end
        bus.btn_raw = 1'b0;
        repeat (12) begin tick(); if (bus.btn_press) n++; end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.data_in = '0;
        bus.data_valid = 1'b0;
        bus.freeze = 1'b0;
        bus.btn_raw = 1'b0;
        bus.auto_en = 1'b0;
        tick();
        tick();
        chk("rst_hex", 32'(bus.hex_val), 32'h0);
        chk("rst_page", 32'(bus.page_hi), 32'h0);
        chk("rst_dp", 32'(bus.dp_mask), 32'h0);
        chk("rst_press", 32'(bus.btn_press), 32'h0);
        reset = 1'b0;

        // Capture latency
        bus.data_in = 32'hDEAD_BEEF;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        chk("cap_latency", 32'(bus.hex_val), 32'h0);
        tick();
        chk("cap_hex", 32'(bus.hex_val), 32'h0000_BEEF);
        chk("cap_page", 32'(bus.page_hi), 32'h0);
        chk("cap_dp", 32'(bus.dp_mask), 32'h0);

        // Held button gives one pulse and flips to the upper page
        press_count(pulses);
        chk("btn_pulses", 32'(pulses), 32'd1);
        chk("btn_page", 32'(bus.page_hi), 32'h1);
        chk("btn_hex", 32'(bus.hex_val), 32'h0000_DEAD);
        chk("btn_dp", 32'(bus.dp_mask), 32'h8);

        // Two-cycle glitch is rejected
        pulses = 0;
        bus.btn_raw = 1'b1;
        tick();
        tick();
        bus.btn_raw = 1'b0;
        repeat (12) begin tick(); if (bus.btn_press) pulses++; end
        chk("glitch_pulses", 32'(pulses), 32'd0);
        chk("glitch_page", 32'(bus.page_hi), 32'h1);

        // Freeze blocks capture
        bus.freeze = 1'b1;
        bus.data_in = 32'h1234_5678;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        tick();
        tick();
        chk("freeze_hold", 32'(bus.hex_val), 32'h0000_DEAD);
        bus.freeze = 1'b0;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        tick();
        chk("unfreeze_hex", 32'(bus.hex_val), 32'h0000_1234);

        // Auto cycling every 8 cycles (starting from page 1)
        bus.auto_en = 1'b1;
        repeat (7) tick();
        chk("auto_before1", 32'(bus.page_hi), 32'h1);
        tick();
        chk("auto_flip1", 32'(bus.page_hi), 32'h0);
        repeat (7) tick();
        chk("auto_before2", 32'(bus.page_hi), 32'h0);
        tick();
        chk("auto_flip2", 32'(bus.page_hi), 32'h1);
        bus.auto_en = 1'b0;
        tick();
        chk("auto_dp", 32'(bus.dp_mask), 32'h8);

        // Drop auto_en at timer=5; count must restart on re-enable
        bus.auto_en = 1'b1;
        repeat (5) tick();
        bus.auto_en = 1'b0;
        repeat (3) tick();
        bus.auto_en = 1'b1;
        repeat (7) tick();
        chk("reen_no_early", 32'(bus.page_hi), 32'h1);
        tick();
        chk("reen_flip", 32'(bus.page_hi), 32'h0);
        bus.auto_en = 1'b0;
        tick();

        // Press coincides with timeout, plus a capture on the same edge
        bus.btn_raw = 1'b1;
        bus.auto_en = 1'b1;
        repeat (7) tick();
        chk("coin_press", 32'(bus.btn_press), 32'h1);
        bus.data_in = 32'hCAFE_F00D;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        chk("coin_single_flip", 32'(bus.page_hi), 32'h1);
        chk("coin_press_end", 32'(bus.btn_press), 32'h0);
        tick();
        chk("coin_hex", 32'(bus.hex_val), 32'h0000_CAFE);
        repeat (6) tick();
        chk("coin_timer_restart", 32'(bus.page_hi), 32'h1);
        tick();
        chk("coin_next_flip", 32'(bus.page_hi), 32'h0);
        bus.auto_en = 1'b0;
        repeat (3) begin tick(); if (bus.btn_press) pulses++; end
        chk("held_no_repeat", 32'(pulses), 32'd0);
        bus.btn_raw = 1'b0;
        repeat (12) tick();

        // Reset mid-debounce with page 1
        press_count(pulses);
        chk("pre_rst_page", 32'(bus.page_hi), 32'h1);
        bus.btn_raw = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_hex", 32'(bus.hex_val), 32'h0);
        chk("mid_rst_page", 32'(bus.page_hi), 32'h0);
        chk("mid_rst_dp", 32'(bus.dp_mask), 32'h0);
        chk("mid_rst_press", 32'(bus.btn_press), 32'h0);
        reset = 1'b0;
        repeat (6) tick();
        chk("post_rst_nopress", 32'(bus.btn_press), 32'h0);
        tick();
        chk("post_rst_press", 32'(bus.btn_press), 32'h1);
        tick();
        chk("post_rst_page", 32'(bus.page_hi), 32'h1);
        bus.btn_raw = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
